// File: rtl/cic_comp_fir_if.sv
// Stream, coefficient-port and status bundle for cic_comp_fir.
// The filter is the slave; the upstream CIC / control side is the master.
interface cic_comp_fir_if #(
  parameter int DATA_WIDTH = 32,
  parameter int COEF_WIDTH = 18,
  parameter int TAPS       = 16
);
  localparam int ADDR_WIDTH = $clog2(TAPS);

  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic                         coef_wr_en;
  logic        [ADDR_WIDTH-1:0] coef_addr;
  logic signed [COEF_WIDTH-1:0] coef_wdata;
  logic                         busy;
  logic                         overrun;
  logic                         overrun_clr;

  modport slave (
    input  in_data, in_valid, out_ready, coef_wr_en, coef_addr, coef_wdata, overrun_clr,
    output in_ready, out_data, out_valid, busy, overrun
  );

  modport master (
    output in_data, in_valid, out_ready, coef_wr_en, coef_addr, coef_wdata, overrun_clr,
    input  in_ready, out_data, out_valid, busy, overrun
  );
endinterface

// File: rtl/cic_comp_fir.sv
// CIC droop-compensation FIR with decimation. One multiply-accumulate per
// clock over a circular delay line, round-half-up and saturate, then hold the
// result until the consumer takes it. Samples arriving while busy are dropped
// and reported through a sticky overrun flag.
module cic_comp_fir #(
  parameter int DATA_WIDTH = 32,
  parameter int COEF_WIDTH = 18,
  parameter int TAPS       = 16,   // power of 2, >= 4
  parameter int DECIM      = 2     // 1 .. TAPS
) (
  input logic           clk,
  input logic           rst_n,
  cic_comp_fir_if.slave bus
);
  localparam int AW     = $clog2(TAPS);
  localparam int PW     = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
  // Full-precision sum of TAPS products; never wraps.
  localparam int ACC_W  = DATA_WIDTH + COEF_WIDTH + AW;

  // Half an output LSB in Q1.(COEF_WIDTH-1) accumulator units.
  localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(1) << (COEF_WIDTH - 2);
  localparam logic signed [ACC_W-1:0] SAT_MAX  =
    {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN  =
    {{(ACC_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND,
    OUT
  } state_e;

  state_e state_q, state_d;

  logic signed [DATA_WIDTH-1:0] dline_q [TAPS];
  logic signed [COEF_WIDTH-1:0] coef_q  [TAPS];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] phase_q, phase_d, phase_inc;

  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_W-1:0]      prod_ext;
  logic signed [ACC_W-1:0]      rnd_sum;
  logic signed [ACC_W-1:0]      rnd_shift;
  logic signed [DATA_WIDTH-1:0] sat_val;

  logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;
  logic                         overrun_q, overrun_d;

  logic accept;
  logic drop;
  logic coef_we;

  // Input side handshake: the block only listens while idle, and the CIC
  // cannot be stalled, so anything offered while busy is lost.
  assign accept  = bus.in_valid && (state_q == IDLE);
  assign drop    = bus.in_valid && (state_q != IDLE);
  assign coef_we = bus.coef_wr_en && (state_q == IDLE);

  assign phase_inc = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);

  // Datapath: tap k reads x[n-k], which sits k+1 slots behind the write
  // pointer; the power-of-2 depth makes the subtraction wrap for free.
  always_comb begin
    rd_addr   = wr_ptr_q - AW'(1) - k_q;
    prod      = coef_q[k_q] * dline_q[rd_addr];
    prod_ext  = ACC_W'(prod);
    rnd_sum   = acc_q + RND_BIAS;
    rnd_shift = rnd_sum >>> (COEF_WIDTH - 1);
    if (rnd_shift > SAT_MAX) begin
      sat_val = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end else if (rnd_shift < SAT_MIN) begin
      sat_val = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end else begin
      sat_val = rnd_shift[DATA_WIDTH-1:0];
    end
  end

  // Next-state and control: IDLE collects DECIM samples, MAC walks the taps,
  // ROUND produces the sample, OUT holds it until the consumer accepts.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    phase_d     = phase_q;
    k_d         = k_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    // A drop in the same cycle as a clear wins, so no loss goes unreported.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (bus.overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          phase_d  = phase_inc;
          if (phase_inc == '0) begin
            state_d = MAC;
            k_d     = '0;
            acc_d   = '0;
          end
        end
      end
      MAC: begin
        acc_d = acc_q + prod_ext;
        k_d   = k_q + AW'(1);
        if (k_q == AW'(TAPS - 1)) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        out_data_d  = sat_val;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and scalar datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge value of every other register.
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      phase_q     <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      phase_q     <= phase_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Delay line and coefficient bank; coefficients are frozen outside IDLE so
  // a running MAC always sees one consistent set.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these small arrays are deliberately reset to zero so the first
    // outputs after reset see a clean history and a known coefficient set;
    // that rules out mapping them onto RAM macros without reset.
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        dline_q[i] <= '0;
        coef_q[i]  <= '0;
      end
    end else begin
      if (accept) begin
        dline_q[wr_ptr_q] <= bus.in_data;
      end
      if (coef_we) begin
        coef_q[bus.coef_addr] <= bus.coef_wdata;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Self-checking bench for cic_comp_fir. A behavioural model keeps the last
// TAPS accepted samples and the coefficient set as plain integers, computes
// each expected output as a dot product with round-half-up and saturation,
// and each scenario task compares the DUT against it or against fixed values.
module tb_cic_comp_fir;
  localparam int DW    = 32;
  localparam int CW    = 18;
  localparam int TAPS  = 16;
  localparam int DECIM = 2;
  localparam int AW    = $clog2(TAPS);
  localparam int LAT   = TAPS + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  longint        m_hist [TAPS];   // m_hist[0] is the newest accepted sample
  longint        m_coef [TAPS];
  int            m_phase;
  logic [DW-1:0] exp_q [$];
  int            last_acc_cyc;

  cic_comp_fir_if #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .TAPS(TAPS)) bus ();

  cic_comp_fir #(
    .DATA_WIDTH(DW),
    .COEF_WIDTH(CW),
    .TAPS      (TAPS),
    .DECIM     (DECIM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) begin
      m_hist[i] = 0;
      m_coef[i] = 0;
    end
    m_phase = 0;
    exp_q.delete();
  endfunction

  function automatic logic [DW-1:0] model_result();
    longint acc;
    longint r;
    longint smax;
    longint smin;
    logic [63:0] r_bits;
    acc  = 0;
    smax = (64'sd1 <<< (DW - 1)) - 1;
    smin = -(64'sd1 <<< (DW - 1));
    for (int k = 0; k < TAPS; k++) acc += m_coef[k] * m_hist[k];
    r = (acc + (64'sd1 <<< (CW - 2))) >>> (CW - 1);
    if (r > smax) r = smax;
    else if (r < smin) r = smin;
    r_bits = r;
    return r_bits[DW-1:0];
  endfunction

  function automatic void model_accept(input logic [DW-1:0] x);
    for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = longint'($signed(x));
    m_phase   = (m_phase + 1) % DECIM;
    if (m_phase == 0) exp_q.push_back(model_result());
  endfunction

  function automatic logic [DW-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // ---------------- stimulus helpers (all start and end at a negedge) ----
  task automatic do_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.coef_wr_en  = 1'b0;
    bus.overrun_clr = 1'b0;
    bus.out_ready   = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_coef(input int addr, input logic [CW-1:0] val, input bit to_model);
    bus.coef_wr_en = 1'b1;
    bus.coef_addr  = AW'(addr);
    bus.coef_wdata = val;
    @(negedge clk);
    bus.coef_wr_en = 1'b0;
    if (to_model) m_coef[addr] = longint'($signed(val));
  endtask

  task automatic load_random_coefs();
    for (int k = 0; k < TAPS; k++) write_coef(k, CW'($urandom), 1'b1);
  endtask

  task automatic send_sample(input logic [DW-1:0] x);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    if (bus.in_ready) begin
      model_accept(x);
      last_acc_cyc = cyc;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Returns at the negedge where out_valid is first seen (no handshake yet).
  task automatic wait_valid(input int budget, output logic [DW-1:0] d,
                            output int lat, output bit ok);
    ok  = 1'b0;
    d   = 'x;
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      if (bus.out_valid) begin
        ok  = 1'b1;
        d   = bus.out_data;
        lat = cyc - last_acc_cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [DW-1:0] d, want;
    int lat, saw_valid, saw_busy;
    bit ok;
    do_reset();
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy, bus.overrun, bus.out_data} !== {4'b0100, {DW{1'b0}}})
      $display("FAIL reset_state: v/r/b/o=%b%b%b%b data=%h, want 0100 data=0",
               bus.out_valid, bus.in_ready, bus.busy, bus.overrun, bus.out_data);
    else n_pass++;

    load_random_coefs();
    send_sample($urandom);
    send_sample($urandom);
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1) $display("FAIL reset_busy_mid_mac: busy=%b want 1", bus.busy);
    else n_pass++;

    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy, bus.overrun, bus.out_data} !== {4'b0100, {DW{1'b0}}})
      $display("FAIL reset_mid_mac: v/r/b/o=%b%b%b%b data=%h, want 0100 data=0",
               bus.out_valid, bus.in_ready, bus.busy, bus.overrun, bus.out_data);
    else n_pass++;
    rst_n = 1'b1;

    saw_valid = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid++;
    end
    n_checks++;
    if (saw_valid != 0) $display("FAIL reset_no_partial: out_valid seen %0d cycles, want 0", saw_valid);
    else n_pass++;

    load_random_coefs();
    send_sample($urandom);
    saw_valid = 0;
    saw_busy  = 0;
    repeat (30) begin
      if (bus.out_valid) saw_valid++;
      if (bus.busy) saw_busy++;
      @(negedge clk);
    end
    n_checks++;
    if (saw_valid != 0 || saw_busy != 0)
      $display("FAIL reset_one_sample_idle: valid=%0d busy=%0d cycles, want 0/0", saw_valid, saw_busy);
    else n_pass++;

    send_sample($urandom);
    want = pop_exp();
    wait_valid(40, d, lat, ok);
    n_checks++;
    if (d !== want) $display("FAIL reset_first_output: got %h want %h", d, want);
    else n_pass++;
    n_checks++;
    if (!ok || lat != LAT) $display("FAIL reset_first_latency: got %0d want %0d", lat, LAT);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_impulse();
    logic [DW-1:0] d, want;
    int lat;
    bit ok;
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, CW'(1000 * (k + 1)), 1'b1);
    for (int j = 0; j < 18; j++) begin
      send_sample((j == 0) ? DW'(131072) : '0);
      if (j % 2 == 0) begin
        repeat (19) @(negedge clk);
      end else begin
        want = (j / 2 < 8) ? DW'(2000 * (j / 2 + 1)) : '0;
        wait_valid(40, d, lat, ok);
        n_checks++;
        if (d !== want) $display("FAIL impulse_out[%0d]: got %0d want %0d", j / 2, $signed(d), $signed(want));
        else n_pass++;
        n_checks++;
        if (!ok || lat != LAT) $display("FAIL impulse_latency[%0d]: got %0d want %0d", j / 2, lat, LAT);
        else n_pass++;
        @(negedge clk);
        repeat (2) @(negedge clk);
      end
    end
  endtask

  task automatic test_rounding();
    int vin  [4] = '{3, -3, 1, -1};
    int vexp [4] = '{2, -1, 1, 0};
    logic [DW-1:0] d;
    int lat;
    bit ok;
    do_reset();
    write_coef(0, CW'(65536), 1'b1);
    for (int i = 0; i < 4; i++) begin
      send_sample('0);
      send_sample(DW'(vin[i]));
      wait_valid(40, d, lat, ok);
      n_checks++;
      if (!ok || d !== DW'(vexp[i]))
        $display("FAIL rounding[%0d]: in %0d got %0d want %0d", i, vin[i], $signed(d), vexp[i]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] vals [2];
    logic [DW-1:0] d, want;
    int lat;
    bit ok;
    vals[0] = 32'h7FFF_FFFF;
    vals[1] = 32'h8000_0000;
    for (int v = 0; v < 2; v++) begin
      do_reset();
      for (int k = 0; k < TAPS; k++) write_coef(k, CW'(131071), 1'b1);
      for (int p = 0; p < TAPS / 2; p++) begin
        send_sample(vals[v]);
        send_sample(vals[v]);
        want = pop_exp();
        wait_valid(40, d, lat, ok);
        n_checks++;
        if (!ok || d !== want) $display("FAIL saturation_model[%0d.%0d]: got %h want %h", v, p, d, want);
        else n_pass++;
        @(negedge clk);
      end
      n_checks++;
      if (d !== vals[v]) $display("FAIL saturation_rail[%0d]: got %h want %h", v, d, vals[v]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] x, held, want;
    int n_acc;
    bit got_valid, unstable;
    do_reset();
    load_random_coefs();
    bus.out_ready = 1'b0;
    n_acc     = 0;
    got_valid = 1'b0;
    unstable  = 1'b0;
    held      = 'x;
    for (int i = 0; i < 30; i++) begin
      x            = $urandom;
      bus.in_valid = 1'b1;
      bus.in_data  = x;
      if (bus.in_ready) begin
        model_accept(x);
        n_acc++;
      end
      if (bus.out_valid) begin
        if (!got_valid) begin
          got_valid = 1'b1;
          held      = bus.out_data;
        end else if (bus.out_data !== held) begin
          unstable = 1'b1;
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (n_acc != DECIM) $display("FAIL bp_accept_count: got %0d want %0d", n_acc, DECIM);
    else n_pass++;
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy, bus.overrun} !== 4'b1011)
      $display("FAIL bp_stalled_status: v/r/b/o got %b%b%b%b want 1011",
               bus.out_valid, bus.in_ready, bus.busy, bus.overrun);
    else n_pass++;
    want = pop_exp();
    n_checks++;
    if (held !== want) $display("FAIL bp_held_data: got %h want %h", held, want);
    else n_pass++;
    n_checks++;
    if (unstable) $display("FAIL bp_data_stable: out_data changed while stalled, want stable");
    else n_pass++;

    bus.overrun_clr = 1'b1;     // in_valid still high: drop coincides with clear
    @(negedge clk);
    bus.overrun_clr = 1'b0;
    bus.in_valid    = 1'b0;
    n_checks++;
    if (bus.overrun !== 1'b1) $display("FAIL bp_clr_vs_drop: overrun=%b want 1", bus.overrun);
    else n_pass++;
    bus.overrun_clr = 1'b1;
    @(negedge clk);
    bus.overrun_clr = 1'b0;
    n_checks++;
    if (bus.overrun !== 1'b0) $display("FAIL bp_overrun_clear: overrun=%b want 0", bus.overrun);
    else n_pass++;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== want)
      $display("FAIL bp_still_holding: valid=%b data=%h want 1 %h", bus.out_valid, bus.out_data, want);
    else n_pass++;

    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010)
      $display("FAIL bp_handshake: v/r/b got %b%b%b want 010", bus.out_valid, bus.in_ready, bus.busy);
    else n_pass++;
  endtask

  task automatic test_coef_lock();
    logic [DW-1:0] d, want, x;
    logic [CW-1:0] newc, newc2;
    int lat;
    bit ok;
    do_reset();
    load_random_coefs();
    send_sample($urandom | 32'h0100_0000);
    send_sample($urandom | 32'h0100_0000);
    n_checks++;
    if (bus.busy !== 1'b1) $display("FAIL lock_busy: busy=%b want 1", bus.busy);
    else n_pass++;
    newc = CW'(m_coef[TAPS-1]) ^ CW'(18'h15555);
    write_coef(TAPS - 1, newc, 1'b0);   // lands mid-MAC: must be ignored
    want = pop_exp();
    wait_valid(40, d, lat, ok);
    n_checks++;
    if (!ok || d !== want) $display("FAIL lock_old_set: got %h want %h", d, want);
    else n_pass++;
    @(negedge clk);

    write_coef(TAPS - 1, newc, 1'b1);   // idle: takes effect
    send_sample($urandom | 32'h0100_0000);
    send_sample($urandom | 32'h0100_0000);
    want = pop_exp();
    wait_valid(40, d, lat, ok);
    n_checks++;
    if (!ok || d !== want) $display("FAIL lock_new_set: got %h want %h", d, want);
    else n_pass++;
    @(negedge clk);

    // Coefficient write in the same cycle as the triggering accept.
    send_sample($urandom | 32'h0100_0000);
    newc2          = CW'(m_coef[1]) ^ CW'(18'h0AAAA);
    x              = $urandom | 32'h0100_0000;
    bus.coef_wr_en = 1'b1;
    bus.coef_addr  = AW'(1);
    bus.coef_wdata = newc2;
    bus.in_valid   = 1'b1;
    bus.in_data    = x;
    m_coef[1]      = longint'($signed(newc2));
    model_accept(x);
    last_acc_cyc   = cyc;
    @(negedge clk);
    bus.coef_wr_en = 1'b0;
    bus.in_valid   = 1'b0;
    want = pop_exp();
    wait_valid(40, d, lat, ok);
    n_checks++;
    if (!ok || d !== want) $display("FAIL lock_same_cycle_write: got %h want %h", d, want);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [DW-1:0] a, b, d, want, held;
    int lat, stall;
    bit ok, unstable;
    do_reset();
    load_random_coefs();
    for (int p = 0; p < 12; p++) begin
      if ($urandom_range(0, 2) == 0) write_coef(int'($urandom_range(0, TAPS - 1)), CW'($urandom), 1'b1);
      stall = int'($urandom_range(0, 4));
      bus.out_ready = (stall == 0);
      a = $urandom;
      b = $urandom;
      if (p % 2 == 1) begin
        a = {{12{a[31]}}, a[31:12]};
        b = {{12{b[31]}}, b[31:12]};
      end
      send_sample(a);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_sample(b);
      want = pop_exp();
      wait_valid(40, d, lat, ok);
      n_checks++;
      if (!ok || d !== want) $display("FAIL rand_data[%0d]: got %h want %h", p, d, want);
      else n_pass++;
      n_checks++;
      if (lat != LAT) $display("FAIL rand_latency[%0d]: got %0d want %0d", p, lat, LAT);
      else n_pass++;
      held     = d;
      unstable = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        if (bus.out_valid !== 1'b1 || bus.out_data !== held) unstable = 1'b1;
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (unstable || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
        $display("FAIL rand_handshake[%0d]: unstable=%b valid=%b ready=%b want 0 0 1",
                 p, unstable, bus.out_valid, bus.in_ready);
      else n_pass++;
    end
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b1;
    bus.coef_wr_en  = 1'b0;
    bus.coef_addr   = '0;
    bus.coef_wdata  = '0;
    bus.overrun_clr = 1'b0;
    last_acc_cyc    = 0;
    model_reset();
    test_reset();
    test_impulse();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_coef_lock();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, want completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/cic_comp_fir.md
Name: cic_comp_fir

Overview:
- Sequential-MAC FIR, decimate-by-2, placed directly downstream of the CIC decimator.
- Flattens the CIC passband droop and halves the sample rate again before baseband processing.
- Consumes the CIC output_valid/data stream, which has no backpressure. Samples arriving while the block is busy are dropped and flagged.
- Coefficients are runtime-loadable; one multiply-accumulate per clock.

Parameters:
- DATA_WIDTH, 32: signed input/output sample width.
- COEF_WIDTH, 18: signed coefficient width, Q1.(COEF_WIDTH-1).
- TAPS, 16: filter length; must be a power of 2, >= 4.
- DECIM, 2: decimation factor; 1 <= DECIM <= TAPS.

Ports:
- clk  in  1  processing clock
- rst_n  in  1  reset; asynchronous, active-low
- in_data  in  DATA_WIDTH  signed input sample (CIC data_out)
- in_valid  in  1  input sample valid (CIC output_valid)
- in_ready  out  1  block can accept a sample this cycle
- out_data  out  DATA_WIDTH  signed filtered, decimated sample
- out_valid  out  1  out_data valid; held until accepted
- out_ready  in  1  downstream accepts out_data
- coef_wr_en  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  coefficient index
- coef_wdata  in  COEF_WIDTH  signed coefficient value
- busy  out  1  state != IDLE
- overrun  out  1  sticky flag: sample dropped
- overrun_clr  in  1  synchronous clear of overrun

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low.
- Reset values:
  - state IDLE; out_data 0; out_valid 0; in_ready 1; overrun 0; busy 0.
  - Delay line, all coefficients, write pointer, phase counter and accumulator are all 0.
- Input acceptance: a sample is accepted when in_valid && in_ready.
  - It is written to the circular delay line at wr_ptr, then wr_ptr increments mod TAPS.
  - phase increments mod DECIM.
- in_ready is 1 only in IDLE.
- in_valid && !in_ready: the sample is dropped and overrun is set. Delay line, wr_ptr and phase are unchanged.
- Overrun flag: overrun_clr clears it. If a set and a clear coincide, set wins.
- State machine:
  - IDLE -> MAC on an accepted sample that brings phase to 0 (the DECIM-th accept). Otherwise stay in IDLE.
  - MAC: runs exactly TAPS cycles, k = 0..TAPS-1.
    - Cycle k adds coef[k] * x[n-k] to the accumulator.
    - x[n] is the newest accepted sample; its address is (wr_ptr-1-k) mod TAPS.
    - The accumulator is cleared on MAC entry.
    - Accumulator width is DATA_WIDTH + COEF_WIDTH + $clog2(TAPS), signed, full precision, no wrap.
  - MAC -> ROUND after k = TAPS-1.
  - ROUND: compute (acc + 2^(COEF_WIDTH-2)) >>> (COEF_WIDTH-1), i.e. round half toward +inf. Saturate to signed DATA_WIDTH: above max gives 2^(DATA_WIDTH-1)-1, below min gives -2^(DATA_WIDTH-1). Register the result to out_data, set out_valid, go to OUT.
  - OUT: hold out_data and out_valid stable until out_ready. On out_valid && out_ready, clear out_valid and go to IDLE; in_ready = 1 on the next cycle.
- Latency: the triggering accept occurs at cycle T. out_valid rises at cycle T+TAPS+2.
- Minimum input spacing: inputs must be at least TAPS+3 cycles apart per DECIM group if out_ready is held high.
- Coefficient writes: honoured only in IDLE (coef[coef_addr] <= coef_wdata) and ignored otherwise.
  - A write and an accepted sample in the same IDLE cycle are both performed.
  - The new coefficient is used by the MAC that follows.
- out_ready has no effect unless out_valid = 1.
- Reset mid-operation (any state): immediately returns to reset values. No partial output is emitted afterwards.

Test Plan:
- Reset: assert rst_n low mid-MAC -> next cycle out_valid=0, out_data=0, in_ready=1, busy=0, overrun=0. After release, the first output requires DECIM fresh samples.
- Impulse/decimation: load coef[k]=1000*(k+1); feed 131072 followed by zeros, spaced 20 cycles, out_ready=1 -> outputs 2000, 4000, 6000, ..., 16000, then 0. out_valid occurs exactly TAPS+2 cycles after each second accept.
- Rounding: coef[0]=65536, others 0; input pairs (0,3) -> 2; (0,-3) -> -1; (0,1) -> 1; (0,-1) -> 0.
- Saturation: all coef=131071; constant input 0x7FFFFFFF -> out 0x7FFFFFFF; constant 0x80000000 -> out 0x80000000.
- Backpressure/overrun: out_ready=0, in_valid held 1 -> in_ready drops after the second accept; overrun=1; out_data stable. Set out_ready=1 -> one handshake, then in_ready=1. Pulse overrun_clr -> overrun=0, unless a drop occurs in the same cycle, in which case it stays 1.
- Coefficient lock: write coef during MAC -> ignored, and the output matches the old set. The same write in IDLE takes effect on the next output.
